// File: rtl/regfile_mp.sv
// regfile_mp: multi-port ARM register file with a pending-write scoreboard.
// R0..R(2**ADDR_W-2) are stored. The top index is a PC alias that reads back
// the external pc input.
// Ports:
//   clk, reset            : clock and synchronous active-low reset
//   we_a/wa_a/wd_a        : write port A (normal results)
//   we_b/wa_b/wd_b        : write port B (long-multiply high word)
//   ra / rd               : NREAD packed read addresses / combinational read data
//   pc                    : value returned for reads of the PC index
//   sb_set/sb_addr        : mark the first destination as pending
//   sb_set2/sb_addr2      : mark the second destination as pending
//   busy                  : per read port, the register has an outstanding write
//   wr_conflict           : registered flag, both ports wrote one address last cycle
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREAD  = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we_a,
  input  logic [ADDR_W-1:0]         wa_a,
  input  logic [DATA_W-1:0]         wd_a,
  input  logic                      we_b,
  input  logic [ADDR_W-1:0]         wa_b,
  input  logic [DATA_W-1:0]         wd_b,
  input  logic [NREAD*ADDR_W-1:0]   ra,
  input  logic [DATA_W-1:0]         pc,
  output logic [NREAD*DATA_W-1:0]   rd,
  input  logic                      sb_set,
  input  logic [ADDR_W-1:0]         sb_addr,
  input  logic                      sb_set2,
  input  logic [ADDR_W-1:0]         sb_addr2,
  output logic [NREAD-1:0]          busy,
  output logic                      wr_conflict
);

  localparam int unsigned NREG = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              acc_a;
  logic              acc_b;

  // Writes to the PC alias are dropped entirely.
  assign acc_a = we_a && (wa_a != PC_IDX);
  assign acc_b = we_b && (wa_b != PC_IDX);

  // Scoreboard next state: clears from accepted writes, then sets so a newly
  // issued producer wins over a retiring one on the same register.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (acc_a && (wa_a == ADDR_W'(i))) pending_nxt[i] = 1'b0;
      if (acc_b && (wa_b == ADDR_W'(i))) pending_nxt[i] = 1'b0;
      if (sb_set  && (sb_addr  == ADDR_W'(i))) pending_nxt[i] = 1'b1;
      if (sb_set2 && (sb_addr2 == ADDR_W'(i))) pending_nxt[i] = 1'b1;
    end
  end

  // Storage, scoreboard and conflict flag; port B is applied last so it wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      pending     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (acc_a && (wa_a == ADDR_W'(i))) regs[i] <= wd_a;
        if (acc_b && (wa_b == ADDR_W'(i))) regs[i] <= wd_b;
      end
      pending     <= pending_nxt;
      wr_conflict <= acc_a && acc_b && (wa_a == wa_b);
    end
  end

  // Read ports: PC alias, stored value, optional same-cycle forwarding.
  always_comb begin
    rd   = '0;
    busy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;
      logic              pend;
      logic              hit_a;
      logic              hit_b;
      addr  = ra[p*ADDR_W +: ADDR_W];
      val   = '0;
      pend  = 1'b0;
      for (int unsigned j = 0; j < NREG; j++) begin
        if (addr == ADDR_W'(j)) begin
          val  = regs[j];
          pend = pending[j];
        end
      end
      hit_a = (BYPASS != 0) && acc_a && (wa_a == addr);
      hit_b = (BYPASS != 0) && acc_b && (wa_b == addr);
      if (addr == PC_IDX) begin
        rd[p*DATA_W +: DATA_W] = pc;
        busy[p]                = 1'b0;
      end else begin
        if (hit_b)      val = wd_b;
        else if (hit_a) val = wd_a;
        rd[p*DATA_W +: DATA_W] = val;
        busy[p]                = pend && !(hit_a || hit_b);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding instance
// share all stimulus.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            we_a, we_b, sb_set, sb_set2;
  logic [AW-1:0]   wa_a, wa_b, sb_addr, sb_addr2;
  logic [DW-1:0]   wd_a, wd_b, pc;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd_y, rd_n;
  logic [NR-1:0]   busy_y, busy_n;
  logic            wc_y, wc_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1)) dut_y (
    .clk(clk), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .pc(pc), .rd(rd_y),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_set2(sb_set2), .sb_addr2(sb_addr2),
    .busy(busy_y), .wr_conflict(wc_y)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .pc(pc), .rd(rd_n),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_set2(sb_set2), .sb_addr2(sb_addr2),
    .busy(busy_n), .wr_conflict(wc_n)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 ns after it, outputs are checked 2 ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port(input logic [NR*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  initial begin
    reset = 1'b0; pc = 32'h0000_0108;
    we_a = 1'b1; wa_a = 4'd3; wd_a = 32'h0000_DEAD;
    we_b = 1'b0; wa_b = '0;   wd_b = '0;
    sb_set = 1'b1; sb_addr = 4'd3; sb_set2 = 1'b0; sb_addr2 = '0;
    ra = {4'd0, 4'd15, 4'd3};

    // Reset edge with a write and sb set that must be ignored
    tick();
    reset = 1'b1; we_a = 1'b0; sb_set = 1'b0;
    #1;
    chk("rst_rd_y",   port(rd_y, 0), 32'h0);
    chk("rst_rd_n",   port(rd_n, 0), 32'h0);
    chk("rst_pc",     port(rd_y, 1), 32'h0000_0108);
    chk("rst_busy_y", 32'(busy_y), 32'h0);
    chk("rst_busy_n", 32'(busy_n), 32'h0);
    chk("rst_wc",     32'({wc_y, wc_n}), 32'h0);

    // Dual write to different registers
    tick();
    we_a = 1'b1; wa_a = 4'd2; wd_a = 32'h1111_1111;
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h2222_2222;
    ra = {4'd5, 4'd15, 4'd2};
    #1;
    chk("dual_byp_a",  port(rd_y, 0), 32'h1111_1111);
    chk("dual_byp_b",  port(rd_y, 2), 32'h2222_2222);
    chk("dual_nob_a",  port(rd_n, 0), 32'h0);
    chk("dual_nob_b",  port(rd_n, 2), 32'h0);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("dual_r2_n",   port(rd_n, 0), 32'h1111_1111);
    chk("dual_r5_n",   port(rd_n, 2), 32'h2222_2222);
    chk("dual_r2_y",   port(rd_y, 0), 32'h1111_1111);
    chk("dual_pc",     port(rd_n, 1), 32'h0000_0108);
    chk("dual_wc",     32'({wc_y, wc_n}), 32'h0);

    // Same-address dual write: B wins, conflict flagged for one cycle
    tick();
    we_a = 1'b1; wa_a = 4'd7; wd_a = 32'hAAAA_AAAA;
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'hBBBB_BBBB;
    ra = {4'd5, 4'd15, 4'd7};
    #1;
    chk("conf_byp",    port(rd_y, 0), 32'hBBBB_BBBB);
    chk("conf_wc_pre", 32'({wc_y, wc_n}), 32'h0);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("conf_r7_y",   port(rd_y, 0), 32'hBBBB_BBBB);
    chk("conf_r7_n",   port(rd_n, 0), 32'hBBBB_BBBB);
    chk("conf_wc_1",   32'({wc_y, wc_n}), 32'h3);
    tick();
    #1;
    chk("conf_wc_0",   32'({wc_y, wc_n}), 32'h0);

    // Dual write to the PC index: discarded, no conflict
    we_a = 1'b1; wa_a = 4'd15; wd_a = 32'hFFFF_FFFF;
    we_b = 1'b1; wa_b = 4'd15; wd_b = 32'hEEEE_EEEE;
    ra = {4'd7, 4'd2, 4'd15};
    #1;
    chk("pcw_byp_pc",  port(rd_y, 0), 32'h0000_0108);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("pcw_wc",      32'({wc_y, wc_n}), 32'h0);
    chk("pcw_pc",      port(rd_n, 0), 32'h0000_0108);
    chk("pcw_r2",      port(rd_n, 1), 32'h1111_1111);
    chk("pcw_r7",      port(rd_n, 2), 32'hBBBB_BBBB);

    // Single-port forwarding vs next-cycle visibility
    tick();
    we_a = 1'b1; wa_a = 4'd4; wd_a = 32'h1234_5678;
    ra = {4'd7, 4'd2, 4'd4};
    #1;
    chk("byp_same_y",  port(rd_y, 0), 32'h1234_5678);
    chk("byp_same_n",  port(rd_n, 0), 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    chk("byp_next_n",  port(rd_n, 0), 32'h1234_5678);

    // Scoreboard: mark R9 and R10 pending
    tick();
    sb_set = 1'b1; sb_addr = 4'd9; sb_set2 = 1'b1; sb_addr2 = 4'd10;
    ra = {4'd15, 4'd10, 4'd9};
    #1;
    chk("sb_pre_y",    32'(busy_y), 32'h0);
    tick();
    sb_set = 1'b0; sb_set2 = 1'b0;
    #1;
    chk("sb_set_y",    32'(busy_y), 32'h3);
    chk("sb_set_n",    32'(busy_n), 32'h3);

    // Write R9 clears only R9
    we_a = 1'b1; wa_a = 4'd9; wd_a = 32'h0000_0099;
    #1;
    chk("sb_wr_y",     32'(busy_y), 32'h2);
    chk("sb_wr_n",     32'(busy_n), 32'h3);
    tick();
    we_a = 1'b0;
    #1;
    chk("sb_clr_y",    32'(busy_y), 32'h2);
    chk("sb_clr_n",    32'(busy_n), 32'h2);

    // New producer issued in the same cycle R9 retires: stays pending
    tick();
    sb_set = 1'b1; sb_addr = 4'd9;
    we_a = 1'b1; wa_a = 4'd9; wd_a = 32'h0000_0055;
    tick();
    sb_set = 1'b0; we_a = 1'b0;
    #1;
    chk("sb_setwin_y", 32'(busy_y), 32'h3);
    chk("sb_setwin_n", 32'(busy_n), 32'h3);
    chk("sb_r9",       port(rd_n, 0), 32'h0000_0055);

    // Port B clears R10
    tick();
    we_b = 1'b1; wa_b = 4'd10; wd_b = 32'h0000_0010;
    tick();
    we_b = 1'b0;
    #1;
    chk("sb_bclr_n",   32'(busy_n), 32'h1);

    // Reset with R9 pending discards scoreboard and storage
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ra = {4'd15, 4'd7, 4'd9};
    #1;
    chk("mrst_busy_y", 32'(busy_y), 32'h0);
    chk("mrst_busy_n", 32'(busy_n), 32'h0);
    chk("mrst_r9",     port(rd_n, 0), 32'h0);
    chk("mrst_r7",     port(rd_y, 1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
